// File: rtl/sobel_edge_stage.sv
// -----------------------------------------------------------------------------
// sobel_edge_stage
//
// Four-stage streaming Sobel edge detector. The pipeline runs every cycle, has
// no backpressure, and carries a valid bit alongside each pixel.
//   stage 1 : gray conversion of the three row taps, sop/eop capture
//   stage 2 : 3x3 gray window plus column/row position tracking
//   stage 3 : Gx / Gy gradients (11-bit signed)
//   stage 4 : |Gx|+|Gy| magnitude, mode select, edge accumulator
//
// Ports
//   clk         sole clock, rising edge
//   rst         asynchronous reset, active low
//   in_valid    qualifies the three pixel inputs this cycle
//   pix_cur     pixel at row r        {R,G,B,sop,eop}
//   pix_row1    same column, row r-1  (flags ignored)
//   pix_row2    same column, row r-2  (flags ignored)
//   mode        00 gray passthrough, 01 gradient magnitude, 1x binary edge
//   out_valid   qualifies out_data, 4 cycles after in_valid
//   out_data    {m,m,m,sop,eop}; all zero while out_valid is low
//   edge_count  number of edge pixels in the last completed frame
//
// The output is spatially offset by one line plus one pixel relative to the
// input. Downstream consumers accept this offset; no realignment is done.
// -----------------------------------------------------------------------------
module sobel_edge_stage #(
    parameter int          LINE_WIDTH = 640,
    parameter int          DATA_WIDTH = 26,
    parameter int unsigned THRESHOLD  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] pix_cur,
    input  logic [DATA_WIDTH-1:0] pix_row1,
    input  logic [DATA_WIDTH-1:0] pix_row2,
    input  logic [1:0]            mode,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [19:0]           edge_count
);

    localparam int               COL_W    = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam int               ROW_W    = 11;
    localparam int               ACC_W    = 20;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_MAX  = '1;
    localparam logic [ACC_W-1:0] ACC_MAX  = '1;
    localparam logic [7:0]       THRESH   = 8'(THRESHOLD);
    localparam int               R_MSB    = DATA_WIDTH - 1;
    localparam int               G_MSB    = DATA_WIDTH - 9;
    localparam int               B_MSB    = DATA_WIDTH - 17;

    // (R + 2G + B) >> 2 at 10 bits; the result always fits in 8 bits.
    function automatic logic [7:0] gray_of(input logic [DATA_WIDTH-1:0] p);
        return 8'(({2'b00, p[R_MSB -: 8]} + {1'b0, p[G_MSB -: 8], 1'b0}
                   + {2'b00, p[B_MSB -: 8]}) >> 2);
    endfunction

    // a + 2b + c, one half of a Sobel kernel row/column
    function automatic logic [9:0] wsum(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    // Flags on the row-buffer taps carry no meaning here.
    logic unused_row_flags;
    assign unused_row_flags = ^{pix_row1[1:0], pix_row2[1:0]};

    // ---------------------------------------------------------------- stage 1
    // Index 0 = row r-2 (window top), 1 = row r-1, 2 = row r (window bottom).
    logic       s1_valid_q;
    logic [7:0] s1_gray_q [3];
    logic       s1_sop_q;
    logic       s1_eop_q;

    // NOTE: sequential state uses non-blocking assignments and resets
    // asynchronously, so every register here clears the moment rst falls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_sop_q   <= 1'b0;
            s1_eop_q   <= 1'b0;
            for (int i = 0; i < 3; i++) s1_gray_q[i] <= '0;
        end else begin
            s1_valid_q   <= in_valid;
            s1_sop_q     <= in_valid & pix_cur[1];
            s1_eop_q     <= in_valid & pix_cur[0];
            s1_gray_q[0] <= gray_of(pix_row2);
            s1_gray_q[1] <= gray_of(pix_row1);
            s1_gray_q[2] <= gray_of(pix_cur);
        end
    end

    // ---------------------------------------------------------------- stage 2
    // win_q[row][col]; column 2 holds the newest pixel.
    logic [7:0]       win_q [3][3];
    logic [COL_W-1:0] col_q, col_d, col_now;
    logic [ROW_W-1:0] row_q, row_d, row_now;
    logic             win_cpl;
    logic             s2_valid_q;
    logic             s2_cpl_q;
    logic             s2_sop_q;
    logic             s2_eop_q;

    // col_q/row_q hold the position of the next pixel to arrive; sop forces
    // the arriving pixel to position (0,0) regardless of where we were.
    // NOTE: every always_comb output gets a default first, so no path through
    // the block can leave a value undriven and infer a latch.
    always_comb begin
        col_now = s1_sop_q ? '0 : col_q;
        row_now = s1_sop_q ? '0 : row_q;
        col_d   = col_now + 1'b1;
        row_d   = row_now;
        if (col_now == COL_LAST) begin
            col_d = '0;
            if (row_now != ROW_MAX) row_d = row_now + 1'b1;
        end
        win_cpl = (col_now >= COL_W'(2)) && (row_now >= ROW_W'(2));
    end

    // NOTE: the window is a nine-entry register file, not a RAM, so it is
    // cleared with the rest of the pipeline to give a clean cold start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) win_q[r][c] <= '0;
            col_q      <= '0;
            row_q      <= '0;
            s2_valid_q <= 1'b0;
            s2_cpl_q   <= 1'b0;
            s2_sop_q   <= 1'b0;
            s2_eop_q   <= 1'b0;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_cpl_q   <= s1_valid_q & win_cpl;
            s2_sop_q   <= s1_sop_q;
            s2_eop_q   <= s1_eop_q;
            // Bubbles leave the window and position untouched.
            if (s1_valid_q) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= win_q[r][1];
                    win_q[r][1] <= win_q[r][2];
                    win_q[r][2] <= s1_gray_q[r];
                end
                col_q <= col_d;
                row_q <= row_d;
            end
        end
    end

    // ---------------------------------------------------------------- stage 3
    logic signed [10:0] gx_d, gy_d;
    logic signed [10:0] s3_gx_q, s3_gy_q;
    logic [7:0]         s3_ctr_q;
    logic               s3_valid_q;
    logic               s3_cpl_q;
    logic               s3_sop_q;
    logic               s3_eop_q;

    // Each kernel half is at most 1020, so the difference fits 11-bit signed.
    always_comb begin
        gx_d = $signed({1'b0, wsum(win_q[0][2], win_q[1][2], win_q[2][2])})
             - $signed({1'b0, wsum(win_q[0][0], win_q[1][0], win_q[2][0])});
        gy_d = $signed({1'b0, wsum(win_q[2][0], win_q[2][1], win_q[2][2])})
             - $signed({1'b0, wsum(win_q[0][0], win_q[0][1], win_q[0][2])});
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s3_gx_q    <= '0;
            s3_gy_q    <= '0;
            s3_ctr_q   <= '0;
            s3_valid_q <= 1'b0;
            s3_cpl_q   <= 1'b0;
            s3_sop_q   <= 1'b0;
            s3_eop_q   <= 1'b0;
        end else begin
            s3_gx_q    <= gx_d;
            s3_gy_q    <= gy_d;
            s3_ctr_q   <= win_q[1][1];
            s3_valid_q <= s2_valid_q;
            s3_cpl_q   <= s2_cpl_q;
            s3_sop_q   <= s2_sop_q;
            s3_eop_q   <= s2_eop_q;
        end
    end

    // ---------------------------------------------------------------- stage 4
    logic [10:0]           abs_x, abs_y;
    logic [11:0]           mag_full;
    logic [7:0]            mag, m_sel;
    logic                  edge_hit;
    logic [ACC_W-1:0]      acc_q, acc_d, acc_base, acc_inc;
    logic [ACC_W-1:0]      edge_count_q, edge_count_d;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

    always_comb begin
        abs_x    = s3_gx_q[10] ? 11'(-s3_gx_q) : 11'(s3_gx_q);
        abs_y    = s3_gy_q[10] ? 11'(-s3_gy_q) : 11'(s3_gy_q);
        mag_full = {1'b0, abs_x} + {1'b0, abs_y};
        if (!s3_cpl_q)               mag = 8'h00;
        else if (mag_full > 12'd255) mag = 8'hFF;
        else                         mag = mag_full[7:0];
        edge_hit = (mag >= THRESH);

        // mode is sampled live, so a change applies to the next output.
        unique case (mode)
            2'b00:   m_sel = s3_ctr_q;
            2'b01:   m_sel = mag;
            default: m_sel = edge_hit ? 8'hFF : 8'h00;
        endcase

        out_data_d = '0;
        if (s3_valid_q) begin
            out_data_d[R_MSB -: 8] = m_sel;
            out_data_d[G_MSB -: 8] = m_sel;
            out_data_d[B_MSB -: 8] = m_sel;
            out_data_d[1]          = s3_sop_q;
            out_data_d[0]          = s3_eop_q;
        end

        // sop starts a new frame count; eop publishes it (including this
        // pixel) and restarts. sop+eop together is a one-pixel frame.
        acc_base     = s3_sop_q ? '0 : acc_q;
        acc_inc      = (edge_hit && (acc_base != ACC_MAX)) ? acc_base + 1'b1 : acc_base;
        acc_d        = acc_q;
        edge_count_d = edge_count_q;
        if (s3_valid_q) begin
            if (s3_eop_q) begin
                edge_count_d = acc_inc;
                acc_d        = '0;
            end else begin
                acc_d = acc_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            acc_q        <= '0;
            edge_count_q <= '0;
        end else begin
            out_valid_q  <= s3_valid_q;
            out_data_q   <= out_data_d;
            acc_q        <= acc_d;
            edge_count_q <= edge_count_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign edge_count = edge_count_q;

endmodule
